// File: rtl/instruction_loader_if.sv
// Host byte stream plus instruction-memory write port of the loader.
// slave = loader side, master = host/driver side.
interface instruction_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_write, mem_addr, mem_wdata,
    output cpu_hold, done, error
  );

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_write, mem_addr, mem_wdata,
    input  cpu_hold, done, error
  );
endinterface

// File: rtl/instruction_loader.sv
// Byte-stream program loader: assembles LE words and writes them
// to instruction memory while holding the core in reset.
module instruction_loader #(
  parameter int          MEM_BITS  = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input logic           clock,
  input logic           reset_n,
  instruction_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  // words that fit between BASE_ADDR and the top of memory
  localparam logic [31:0] CAP =
    (32'd1 << (MEM_BITS - 2)) - (BASE_ADDR >> 2);

  logic [2:0]  state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] wdata;
  logic        hold;
  logic        done_q;
  logic        err_q;
  logic        ready;
  logic        xfer;
  logic        last;

  assign ready = (state == S_LEN_LO) ||
                 (state == S_LEN_HI) ||
                 (state == S_DATA);
  assign xfer  = bus.byte_valid & ready;
  assign last  = ({1'b0, word_idx} + 17'd1) == {1'b0, len};

  assign bus.byte_ready = ready;
  assign bus.mem_write  = (state == S_WRITE);
  assign bus.mem_addr   = BASE_ADDR + {14'd0, word_idx, 2'b00};
  assign bus.mem_wdata  = wdata;
  assign bus.cpu_hold   = hold;
  assign bus.done       = done_q;
  assign bus.error      = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      wdata    <= '0;
      hold     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state    <= S_LEN_LO;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold     <= 1'b1;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= bus.byte_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= bus.byte_data;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (len == 16'd0) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            hold   <= 1'b0;
          end else if ({16'd0, len} > CAP) begin
            state <= S_ERROR;
            err_q <= 1'b1;
            hold  <= 1'b0;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            wdata[8*byte_idx +: 8] <= bus.byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3)
              state <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + 16'd1;
          if (last) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            hold   <= 1'b0;
          end else begin
            state <= S_DATA;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: two instances (base 0
// and base 0x100) fed the same host stream.
module tb_instruction_loader;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  instruction_loader_if if0 ();
  instruction_loader_if if1 ();

  assign if1.start      = if0.start;
  assign if1.byte_valid = if0.byte_valid;
  assign if1.byte_data  = if0.byte_data;

  instruction_loader #(
    .MEM_BITS(12), .BASE_ADDR(32'h0)
  ) dut0 (.clock(clock), .reset_n(reset_n), .bus(if0));

  instruction_loader #(
    .MEM_BITS(12), .BASE_ADDR(32'h100)
  ) dut1 (.clock(clock), .reset_n(reset_n), .bus(if1));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         q0[$];
  wr_t         q1[$];
  wr_t         e0, e1;
  logic [31:0] words[$];
  int          total = 0;
  int          bad = 0;
  logic        prev_w0 = 1'b0;
  logic        prev_w1 = 1'b0;

  localparam int BASE0 = 0;
  localparam int BASE1 = 256;
  localparam int CAP0  = 1024 - BASE0 / 4;
  localparam int CAP1  = 1024 - BASE1 / 4;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && if0.mem_write) begin
      check("ready_in_write0", if0.byte_ready, 0);
      check("write_pulse0", prev_w0, 0);
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write0: got %h want none",
                 if0.mem_addr);
      end else begin
        e0 = q0.pop_front();
        check("addr0", if0.mem_addr, e0.addr);
        check("data0", if0.mem_wdata, e0.data);
      end
    end
    prev_w0 <= reset_n & if0.mem_write;
  end

  always @(negedge clock) begin
    if (reset_n && if1.mem_write) begin
      check("ready_in_write1", if1.byte_ready, 0);
      check("write_pulse1", prev_w1, 0);
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write1: got %h want none",
                 if1.mem_addr);
      end else begin
        e1 = q1.pop_front();
        check("addr1", if1.mem_addr, e1.addr);
        check("data1", if1.mem_wdata, e1.data);
      end
    end
    prev_w1 <= reset_n & if1.mem_write;
  end

  task automatic check_reset();
    check("rst_ready0", if0.byte_ready, 0);
    check("rst_write0", if0.mem_write, 0);
    check("rst_flags0", {if0.cpu_hold, if0.done, if0.error}, 0);
    check("rst_addr0", if0.mem_addr, BASE0);
    check("rst_wdata0", if0.mem_wdata, 0);
    check("rst_ready1", if1.byte_ready, 0);
    check("rst_flags1", {if1.cpu_hold, if1.done, if1.error}, 0);
    check("rst_addr1", if1.mem_addr, BASE1);
    check("rst_wdata1", if1.mem_wdata, 0);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    if0.start = 1'b1;
    @(negedge clock);
    if0.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    forever begin
      @(negedge clock);
      if (gaps && $urandom_range(0, 2) == 0) begin
        if0.byte_valid = 1'b0;
      end else begin
        if0.byte_valid = 1'b1;
        if0.byte_data  = b;
        if (if0.byte_ready) begin
          @(posedge clock);
          #1 if0.byte_valid = 1'b0;
          return;
        end
      end
      n++;
      if (n > 40) begin
        total++; bad++;
        $display("FAIL byte_timeout: got ready 0 want 1");
        if0.byte_valid = 1'b0;
        return;
      end
    end
  endtask

  // nfull complete words, then partial bytes of the next word
  task automatic load(input logic [15:0] len, input int nfull,
                      input int partial, input bit gaps,
                      input int mid_start);
    int n;
    pulse_start();
    check("hold_on0", if0.cpu_hold, 1);
    check("flags_clr0", {if0.done, if0.error}, 0);
    check("hold_on1", if1.cpu_hold, 1);
    check("flags_clr1", {if1.done, if1.error}, 0);
    if (len != 0 && int'(len) <= CAP0) begin
      for (int i = 0; i < nfull; i++) begin
        q0.push_back('{addr: BASE0 + 4 * i, data: words[i]});
        q1.push_back('{addr: BASE1 + 4 * i, data: words[i]});
      end
    end
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    if (len == 0 || int'(len) > CAP0) begin
      @(negedge clock);
      check("early_flags0", {if0.done, if0.error}, 0);
      @(negedge clock);
      check("end_flags0", {if0.done, if0.error},
            (len == 0) ? 2'b10 : 2'b01);
      check("end_flags1", {if1.done, if1.error},
            (len == 0) ? 2'b10 : {1'b0, int'(len) > CAP1});
      check("end_hold", {if0.cpu_hold, if1.cpu_hold}, 0);
      check("no_writes", q0.size() + q1.size(), 0);
      return;
    end
    for (int i = 0; i < nfull * 4 + partial; i++) begin
      if (i == mid_start) begin
        pulse_start();
        check("hold_busy", if0.cpu_hold & if1.cpu_hold, 1);
      end
      send_byte(8'(words[i / 4] >> (8 * (i % 4))), gaps);
    end
    if (partial != 0) return;
    n = 0;
    while (!(if0.done && if1.done) && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("done_both", {if0.done, if1.done}, 2'b11);
    check("err_both", {if0.error, if1.error}, 0);
    check("hold_off", {if0.cpu_hold, if1.cpu_hold}, 0);
    check("pending0", q0.size(), 0);
    check("pending1", q1.size(), 0);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    int len;
    if0.start      = 1'b0;
    if0.byte_valid = 1'b0;
    if0.byte_data  = 8'h00;
    repeat (2) @(negedge clock);
    check_reset();
    reset_n = 1'b1;

    words = '{32'h12345678, 32'hDEADBEEF};
    load(16'd2, 2, 0, 1'b0, -1);

    @(negedge clock);
    if0.byte_valid = 1'b1;
    if0.byte_data  = 8'hA5;
    @(negedge clock);
    check("done_not_ready", {if0.byte_ready, if1.byte_ready}, 0);
    if0.byte_valid = 1'b0;

    load(16'd0, 0, 0, 1'b0, -1);
    load(16'h0401, 0, 0, 1'b0, -1);

    rand_words(16);
    load(16'd16, 16, 0, 1'b1, -1);

    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 8);
      rand_words(len);
      load(16'(len), len, 0, 1'($urandom_range(0, 1)), -1);
    end

    rand_words(5);
    load(16'd5, 3, 2, 1'b0, -1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset();
    check("pending_rst", q0.size() + q1.size(), 0);
    @(negedge clock);
    reset_n = 1'b1;
    rand_words(1);
    load(16'd1, 1, 0, 1'b0, -1);

    rand_words(4);
    load(16'd4, 4, 0, 1'b0, 5);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
